// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit instruction per line,
//   sitting between the instruction fetcher and the byte-wide memory arbiter.
// Latency: hit returns 1 cycle after the request edge; miss returns on the edge
//   that accepts the 4th memory byte (4 byte-return cycles + 1).
// Backpressure: rdy=0 freezes every register and the line arrays; one request
//   at a time, in_fetch_ce is only sampled in IDLE; in_flush aborts a miss.
// Optional feature: define ICACHE_PERF_EN to add saturating hit/miss counters.
// Ports:
//   clk, rst (sync, active-low), rdy (global freeze when 0)
//   in_fetch_ce/in_fetch_pc         -> fetch request (pc[1:0] ignored)
//   out_fetch_ce/out_fetch_instr    -> 1-cycle result pulse and instruction
//   in_flush                        -> misbranch abort, preserves valid lines
//   out_mem_ce/out_mem_addr         -> byte read request, held until 4 bytes back
//   in_mem_ce/in_mem_byte           -> returned byte strobe and data
//   out_hit_cnt/out_miss_cnt        -> lookup counters (ICACHE_PERF_EN only)
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetch_ce,
  input  logic [31:0] in_fetch_pc,
  output logic        out_fetch_ce,
  output logic [31:0] out_fetch_instr,
  input  logic        in_flush,
  output logic        out_mem_ce,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ce,
  input  logic [7:0]  in_mem_byte
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] out_hit_cnt,
  output logic [31:0] out_miss_cnt
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  // Latched request address (word aligned) and fill progress.
  logic [31:2] pc_q;
  logic [1:0]  cnt_q;
  logic [23:0] part_q;   // first three bytes of the line being filled

  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  req_hit;
  logic                  lookup;
  logic                  fill_done;

  // Byte offset of the fetch pc never matters for a word-wide cache.
  logic unused_pc_bits;
  assign unused_pc_bits = ^in_fetch_pc[1:0];

  assign req_idx  = in_fetch_pc[INDEX_BITS+1:2];
  assign req_tag  = in_fetch_pc[31:INDEX_BITS+2];
  assign fill_idx = pc_q[INDEX_BITS+1:2];
  assign req_hit  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Next-state logic. Flush wins over both a same-cycle lookup and a
  // same-cycle final byte, so neither lookup nor fill_done is raised then.
  always_comb begin
    state_d   = state_q;
    lookup    = 1'b0;
    fill_done = 1'b0;
    if (in_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fetch_ce) begin
            lookup = 1'b1;
            if (!req_hit) begin
              state_d = MISS;
            end
          end
        end
        MISS: begin
          if (in_mem_ce && (cnt_q == 2'd3)) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Line arrays carry no reset; valid_q alone decides whether a line is live.
  always_ff @(posedge clk) begin
    if (rst && rdy && fill_done) begin
      tag_mem[fill_idx]  <= pc_q[31:INDEX_BITS+2];
      data_mem[fill_idx] <= {in_mem_byte, part_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q         <= '0;
      pc_q            <= '0;
      cnt_q           <= 2'd0;
      part_q          <= '0;
      out_fetch_ce    <= 1'b0;
      out_fetch_instr <= '0;
      out_mem_ce      <= 1'b0;
      out_mem_addr    <= '0;
    end else if (rdy) begin
      out_fetch_ce <= 1'b0;
      if (in_flush) begin
        out_mem_ce <= 1'b0;
        cnt_q      <= 2'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_fetch_ce) begin
              pc_q <= in_fetch_pc[31:2];
              if (req_hit) begin
                out_fetch_ce    <= 1'b1;
                out_fetch_instr <= data_mem[req_idx];
              end else begin
                out_mem_ce   <= 1'b1;
                out_mem_addr <= {in_fetch_pc[31:2], 2'b00};
                cnt_q        <= 2'd0;
              end
            end
          end
          MISS: begin
            if (in_mem_ce) begin
              case (cnt_q)
                2'd0:    part_q[7:0]   <= in_mem_byte;
                2'd1:    part_q[15:8]  <= in_mem_byte;
                2'd2:    part_q[23:16] <= in_mem_byte;
                default: part_q        <= part_q;
              endcase
              // cnt_q wraps back to 0 after the 4th byte.
              cnt_q        <= cnt_q + 2'd1;
              out_mem_addr <= out_mem_addr + 32'd1;
              if (cnt_q == 2'd3) begin
                valid_q[fill_idx] <= 1'b1;
                out_mem_ce        <= 1'b0;
                out_fetch_ce      <= 1'b1;
                out_fetch_instr   <= {in_mem_byte, part_q};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ICACHE_PERF_EN
  // One count per accepted IDLE lookup; a flushed lookup never asserts lookup.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_hit_cnt  <= '0;
      out_miss_cnt <= '0;
    end else if (rdy && lookup) begin
      if (req_hit) begin
        if (out_hit_cnt != 32'hFFFF_FFFF) out_hit_cnt <= out_hit_cnt + 32'd1;
      end else begin
        if (out_miss_cnt != 32'hFFFF_FFFF) out_miss_cnt <= out_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
